// File: rtl/twm_master_pkg.sv
// Shared definitions for the two-wire master: FSM encoding, shifter modes,
// frame sizes and command codes.
package twm_master_pkg;

    typedef enum logic [3:0] {
        IDLE,
        START,
        CMD,
        ADDR,
        WDATA,
        GAP,
        TA,
        RDATA,
        DONE
    } state_e;

    typedef enum logic [1:0] {
        SH_HOLD,
        SH_LOAD,
        SH_SHIFT_OUT,
        SH_SHIFT_IN
    } shift_mode_e;

    localparam int   ADDR_BITS = 8;
    localparam int   DATA_BITS = 16;

    localparam logic CMD_WRITE = 1'b1;
    localparam logic CMD_READ  = 1'b0;

endpackage

// File: rtl/twm_shift16.sv
// 16-bit LSB-first shift register shared by the write path (parallel load,
// serial out) and the read path (serial in, parallel result).
module twm_shift16
    import twm_master_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  shift_mode_e mode,
    input  logic [15:0] din,
    input  logic        sin,
    output logic [15:0] q,
    output logic        sout
);

    // Shift right so bit 0 leaves first; shifting in from the top leaves the
    // first received bit in bit 0 after 16 shifts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else begin
            case (mode)
                SH_LOAD:      q <= din;
                SH_SHIFT_OUT: q <= {1'b0, q[15:1]};
                SH_SHIFT_IN:  q <= {sin, q[15:1]};
                default:      q <= q;
            endcase
        end
    end

    assign sout = q[0];

endmodule

// File: rtl/twm_master.sv
// Two-wire master: serialises a start bit, command, 8-bit address and, for
// writes, 16 data bits onto SDA; for reads it releases SDA, waits for the
// slave's start bit and shifts in 16 data bits.
//
// Handshake: req is sampled only while the FSM is IDLE; a sampled req latches
// cmd/addr/wdata and the inputs are ignored until the next IDLE. Completion is
// a single-cycle rdy pulse; err qualifies that pulse (read timed out) and
// rdata is meaningful only when rdy=1 and err=0.
module twm_master
    import twm_master_pkg::*;
#(
    parameter int TA_TIMEOUT = 8,
    parameter int IDLE_GAP   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        cmd,
    input  logic [7:0]  addr,
    input  logic [15:0] wdata,
    output logic        rdy,
    output logic        err,
    output logic [15:0] rdata,
    output logic        SCL,
    inout  wire         SDA,
    output state_e      state_dbg
);

    localparam int WAIT_MAX = (TA_TIMEOUT > IDLE_GAP) ? TA_TIMEOUT : IDLE_GAP;
    localparam int WCW      = $clog2(WAIT_MAX + 1);

    state_e          state_q, state_d;
    logic            cmd_q;
    logic [7:0]      addr_q;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [WCW-1:0]  wait_cnt_q, wait_cnt_d;
    logic            tail_q, tail_d;
    logic            to_q, to_d;
    logic [15:0]     rdata_q;
    logic            latch;
    logic            rdata_upd;
    shift_mode_e     sh_mode;
    logic [15:0]     sh_q;
    logic            sh_sout;
    logic            sda_oe;
    logic            sda_o;
    logic            scl_o;

    twm_shift16 u_shift (
        .clk   (clk),
        .reset (reset),
        .mode  (sh_mode),
        .din   (wdata),
        .sin   (SDA),
        .q     (sh_q),
        .sout  (sh_sout)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latched request fields, bit/wait counters, timeout flag and read result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_q      <= 1'b0;
            addr_q     <= '0;
            bit_cnt_q  <= '0;
            wait_cnt_q <= '0;
            tail_q     <= 1'b0;
            to_q       <= 1'b0;
            rdata_q    <= '0;
        end else begin
            if (latch) begin
                cmd_q  <= cmd;
                addr_q <= addr;
            end
            bit_cnt_q  <= bit_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            tail_q     <= tail_d;
            to_q       <= to_d;
            if (rdata_upd) begin
                rdata_q <= sh_q;
            end
        end
    end

    // Next-state, counter updates and line drive for each frame phase.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        wait_cnt_d = wait_cnt_q;
        tail_d     = tail_q;
        to_d       = to_q;
        latch      = 1'b0;
        rdata_upd  = 1'b0;
        sh_mode    = SH_HOLD;
        sda_oe     = 1'b1;
        sda_o      = 1'b1;
        scl_o      = 1'b0;
        case (state_q)
            IDLE: begin
                scl_o      = 1'b1;
                to_d       = 1'b0;
                tail_d     = 1'b0;
                bit_cnt_d  = '0;
                wait_cnt_d = '0;
                if (req) begin
                    latch   = 1'b1;
                    sh_mode = SH_LOAD;
                    state_d = START;
                end
            end
            START: begin
                sda_o   = 1'b0;
                state_d = CMD;
            end
            CMD: begin
                sda_o   = cmd_q;
                state_d = ADDR;
            end
            ADDR: begin
                sda_o = addr_q[bit_cnt_q[2:0]];
                if (bit_cnt_q == 4'(ADDR_BITS - 1)) begin
                    bit_cnt_d = '0;
                    state_d   = (cmd_q == CMD_READ) ? TA : WDATA;
                end else begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
            end
            WDATA: begin
                sda_o   = sh_sout;
                sh_mode = SH_SHIFT_OUT;
                if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
                    bit_cnt_d = '0;
                    state_d   = GAP;
                end else begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
            end
            GAP: begin
                if (wait_cnt_q == WCW'(IDLE_GAP - 1)) begin
                    wait_cnt_d = '0;
                    state_d    = DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q + WCW'(1);
                end
            end
            TA: begin
                sda_oe = 1'b0;
                // A start bit on the final allowed cycle still wins over the timeout.
                if (SDA == 1'b0) begin
                    wait_cnt_d = '0;
                    state_d    = RDATA;
                end else if (wait_cnt_q == WCW'(TA_TIMEOUT - 1)) begin
                    wait_cnt_d = '0;
                    to_d       = 1'b1;
                    state_d    = DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q + WCW'(1);
                end
            end
            RDATA: begin
                sda_oe = 1'b0;
                if (tail_q) begin
                    // Slave's trailing high bit: the word is complete, publish it.
                    tail_d    = 1'b0;
                    rdata_upd = 1'b1;
                    state_d   = DONE;
                end else begin
                    sh_mode = SH_SHIFT_IN;
                    if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
                        bit_cnt_d = '0;
                        tail_d    = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            DONE: begin
                scl_o   = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign SDA       = sda_oe ? sda_o : 1'bz;
    assign SCL       = scl_o;
    assign rdy       = (state_q == DONE);
    assign err       = (state_q == DONE) && to_q;
    assign rdata     = rdata_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_twm_master.sv
// Bench for twm_master: a register-file slave on a pulled-up SDA line, a
// memory-based reference model, and a scoreboard of expected completions and
// expected frame bit patterns.
module tb_twm_master;
    import twm_master_pkg::*;

    localparam int TA_TIMEOUT = 8;
    localparam int IDLE_GAP   = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        cmd;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic        rdy;
    logic        err;
    logic [15:0] rdata;
    logic        SCL;
    wire         sda_bus;
    state_e      state_dbg;

    logic        slv_oe = 1'b0;
    logic        slv_o  = 1'b1;

    pullup (sda_bus);
    assign sda_bus = slv_oe ? slv_o : 1'bz;

    twm_master #(
        .TA_TIMEOUT (TA_TIMEOUT),
        .IDLE_GAP   (IDLE_GAP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .cmd       (cmd),
        .addr      (addr),
        .wdata     (wdata),
        .rdy       (rdy),
        .err       (err),
        .rdata     (rdata),
        .SCL       (SCL),
        .SDA       (sda_bus),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- counters, model, scoreboard ----------------
    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] model_mem [256];
    logic [15:0] model_rdata;
    logic [15:0] slave_mem [256];
    int          slv_tt;
    bit          slv_silent;

    logic [48:0] exp_q [$];   // {err, rdata, expected rdy cycle}
    logic [79:0] frm_q [$];   // {SCL-low cycles, bits to compare, bit pattern}

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic wait_idle();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 400) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (guard >= 400) chk("idle_wait", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic run_txn(input logic c, input logic [7:0] a, input logic [15:0] d,
                           input int tt, input bit silent, input bit b2b);
        int          lat;
        int          len;
        logic        e;
        logic [15:0] exp_rd;
        logic [63:0] bits;
        wait_idle();
        if (b2b) begin
            @(negedge clk);
            #1;
        end else begin
            repeat ($urandom_range(2, 4)) begin
                @(negedge clk);
                #1;
            end
        end
        slv_tt     = tt;
        slv_silent = silent;
        cmd   = c;
        addr  = a;
        wdata = d;
        req   = 1'b1;
        if (c == CMD_WRITE) begin
            model_mem[a] = d;
            lat    = 2 + ADDR_BITS + DATA_BITS + IDLE_GAP;
            e      = 1'b0;
            exp_rd = model_rdata;
        end else if (silent) begin
            lat    = 2 + ADDR_BITS + TA_TIMEOUT;
            e      = 1'b1;
            exp_rd = model_rdata;
        end else begin
            lat         = 2 + ADDR_BITS + tt + 1 + DATA_BITS + 1;
            e           = 1'b0;
            exp_rd      = model_mem[a];
            model_rdata = exp_rd;
        end
        bits    = '0;
        bits[1] = c;
        for (int i = 0; i < 8; i++) bits[2 + i] = a[i];
        len = 10;
        if (c == CMD_WRITE) begin
            for (int i = 0; i < 16; i++) bits[10 + i] = d[i];
            for (int g = 0; g < IDLE_GAP; g++) bits[26 + g] = 1'b1;
            len = 26 + IDLE_GAP;
        end
        exp_q.push_back({e, exp_rd, 32'(cyc + 1 + lat)});
        frm_q.push_back({8'(lat), 8'(len), bits});
        @(negedge clk);
        #1;
        req   = 1'b0;
        cmd   = 1'($urandom);
        addr  = 8'($urandom);
        wdata = 16'($urandom);
    endtask

    task automatic done_req_ignored();
        wait_idle();
        req  = 1'b1;
        cmd  = 1'b1;
        addr = 8'h10;
        @(negedge clk);
        #1;
        req = 1'b0;
        repeat (4) begin
            @(negedge clk);
            #1;
            chk("req_in_done_ignored_scl", 64'(SCL), 64'd1);
        end
    endtask

    task automatic reset_mid_write();
        int c0;
        wait_idle();
        @(negedge clk);
        #1;
        c0    = cyc;
        cmd   = 1'b1;
        addr  = 8'h99;
        wdata = 16'hFFDF;
        req   = 1'b1;
        @(negedge clk);
        #1;
        req = 1'b0;
        while (cyc < c0 + 16) @(negedge clk);
        #1;
        chk("abort_wdata_bit5", 64'(sda_bus), 64'd0);
        reset = 1'b1;
        #1;
        chk("abort_sda", 64'(sda_bus), 64'd1);
        chk("abort_scl", 64'(SCL), 64'd1);
        chk("abort_rdy", 64'(rdy), 64'd0);
        chk("abort_err", 64'(err), 64'd0);
        chk("abort_rdata", 64'(rdata), 64'd0);
        chk("abort_state", 64'(state_dbg), 64'(IDLE));
        model_rdata = '0;
        @(negedge clk);
        #1;
        reset = 1'b0;
    endtask

    // ---------------- monitor, frame checker and slave ----------------
    logic        b;
    logic [48:0] e_ent;
    logic [79:0] f_ent;
    logic [63:0] frm_bits = '0;
    logic [63:0] mask;
    int          frm_n = 0;
    int          s_cnt = 0;
    logic        s_cmd = 1'b0;
    logic [7:0]  s_addr = '0;
    logic [15:0] s_wd = '0;
    logic [15:0] s_val;
    int          k;

    always @(negedge clk) begin
        b = sda_bus;
        // completion scoreboard
        if (rdy) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rdy", 64'(rdy), 64'd0);
            end else begin
                e_ent = exp_q.pop_front();
                chk("rdy_cycle", 64'(cyc), 64'(e_ent[31:0]));
                chk("err", 64'(err), 64'(e_ent[48]));
                chk("rdata", 64'(rdata), 64'(e_ent[47:32]));
            end
        end else if (exp_q.size() != 0 && 32'(cyc) > exp_q[0][31:0]) begin
            e_ent = exp_q.pop_front();
            chk("rdy_missing", 64'(rdy), 64'd1);
        end
        // frame bit pattern and SCL-low length
        if (!SCL) begin
            if (frm_n < 64) frm_bits[frm_n] = b;
            frm_n++;
        end else if (frm_n != 0) begin
            if (rdy && frm_q.size() != 0) begin
                f_ent = frm_q.pop_front();
                mask  = (64'd1 << f_ent[71:64]) - 64'd1;
                chk("frame_len", 64'(frm_n), 64'(f_ent[79:72]));
                chk("frame_bits", frm_bits & mask, f_ent[63:0] & mask);
            end
            frm_n    = 0;
            frm_bits = '0;
        end
        if (slv_oe) chk("sda_one_driver", 64'(state_dbg == TA || state_dbg == RDATA), 64'd1);
        // slave: decode the frame, commit writes, answer reads
        if (SCL) begin
            if (s_cmd && s_cnt >= 26) slave_mem[s_addr] = s_wd;
            s_cnt  = 0;
            s_cmd  = 1'b0;
            slv_oe = 1'b0;
        end else begin
            if (s_cnt == 1) s_cmd = b;
            else if (s_cnt >= 2 && s_cnt <= 9) s_addr[s_cnt - 2] = b;
            else if (s_cmd && s_cnt >= 10 && s_cnt <= 25) s_wd[s_cnt - 10] = b;
            if (!s_cmd && s_cnt >= 10) begin
                k = s_cnt - 10 - slv_tt;
                if (slv_silent || k < 0 || k > 16) begin
                    slv_oe = 1'b0;
                end else if (k == 0) begin
                    slv_oe = 1'b1;
                    slv_o  = 1'b0;
                end else begin
                    s_val  = slave_mem[s_addr];
                    slv_oe = 1'b1;
                    slv_o  = s_val[k - 1];
                end
            end
            s_cnt++;
        end
        if (slv_oe) chk("sda_one_driver", 64'(state_dbg == TA || state_dbg == RDATA), 64'd1);
    end

    // ---------------- stimulus ----------------
    initial begin
        reset      = 1'b0;
        req        = 1'b0;
        cmd        = 1'b0;
        addr       = '0;
        wdata      = '0;
        slv_tt     = 2;
        slv_silent = 1'b0;
        for (int i = 0; i < 256; i++) begin
            model_mem[i] = '0;
            slave_mem[i] = '0;
        end
        model_mem[1] = 16'h1234;
        slave_mem[1] = 16'h1234;
        model_rdata  = '0;

        #2 reset = 1'b1;
        @(negedge clk);
        #1;
        chk("reset_sda", 64'(sda_bus), 64'd1);
        chk("reset_scl", 64'(SCL), 64'd1);
        chk("reset_rdy", 64'(rdy), 64'd0);
        chk("reset_err", 64'(err), 64'd0);
        chk("reset_rdata", 64'(rdata), 64'd0);
        chk("reset_state", 64'(state_dbg), 64'(IDLE));
        @(negedge clk);
        #1;
        reset = 1'b0;

        run_txn(1'b1, 8'h3C, 16'hA5F0, 0, 1'b0, 1'b0);
        run_txn(1'b0, 8'h01, 16'h0000, 2, 1'b0, 1'b0);
        run_txn(1'b0, 8'h01, 16'h0000, 0, 1'b1, 1'b1);
        done_req_ignored();
        reset_mid_write();
        run_txn(1'b1, 8'h42, 16'h55AA, 0, 1'b0, 1'b0);
        run_txn(1'b0, 8'h42, 16'h0000, 7, 1'b0, 1'b1);
        run_txn(1'b0, 8'h99, 16'h0000, 3, 1'b0, 1'b1);
        run_txn(1'b1, 8'h07, 16'hBEEF, 0, 1'b0, 1'b1);
        run_txn(1'b0, 8'h07, 16'h0000, 0, 1'b0, 1'b1);

        for (int n = 0; n < 40; n++) begin
            run_txn(1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), 16'($urandom),
                    $urandom_range(0, 7), ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)));
        end

        wait_idle();
        repeat (3) @(negedge clk);
        #1;
        chk("drain_frames", 64'(frm_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/twm_master.md
TWM_MASTER -- requirements
Module: twm_master

Interface
REQ-001 SHALL have parameter TA_TIMEOUT, default 8, the maximum number of cycles it waits for the slave's read-data start bit.
REQ-002 SHALL have parameter IDLE_GAP, default 1, the minimum number of SDA-high cycles driven between frames.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes occur on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port req, input, 1 bit: transaction request, sampled only in IDLE.
REQ-006 SHALL have port cmd, input, 1 bit: 1 = write, 0 = read.
REQ-007 SHALL have port addr, input, 8 bits: register address.
REQ-008 SHALL have port wdata, input, 16 bits: write data.
REQ-009 SHALL have port rdy, output, 1 bit: one-cycle completion pulse.
REQ-010 SHALL have port err, output, 1 bit: asserted together with rdy when a read timed out.
REQ-011 SHALL have port rdata, output, 16 bits: read data, valid when rdy=1 and err=0.
REQ-012 SHALL have port SCL, output, 1 bit: frame-active strobe, low while a frame is in progress, high otherwise.
REQ-013 SHALL have port SDA, inout, 1 bit: two-wire data line, externally pulled high when no side drives it.

Function
REQ-014 SHALL implement a single FSM with states IDLE, START, CMD, ADDR, WDATA, GAP, TA, RDATA, DONE.
REQ-015 In IDLE, SHALL drive SDA=1 and, on req=1, latch cmd/addr/wdata into internal registers and go to START; inputs are ignored after this latch.
REQ-016 In START, SHALL drive SDA=0 for exactly one cycle.
REQ-017 In CMD, SHALL drive the latched cmd bit for one cycle.
REQ-018 In ADDR, SHALL drive addr[0]..addr[7], LSB first, one bit per cycle, using a 4-bit counter that wraps to 0 after 7.
REQ-019 For a write, WDATA SHALL drive wdata[0]..wdata[15], LSB first, over 16 cycles; the frame is 26 cycles from START to the last data bit.
REQ-020 After WDATA, SHALL go to GAP, drive SDA=1 for IDLE_GAP cycles, then go to DONE.
REQ-021 For a read, after addr[7] SHALL release SDA (high-Z) and enter TA.
REQ-022 In TA, SHALL keep SDA released and count cycles; the first sampled SDA=0 (slave start bit) moves the FSM to RDATA.
REQ-023 If TA_TIMEOUT cycles elapse in TA without SDA=0, SHALL go to DONE with err=1 and rdata unchanged.
REQ-024 In RDATA, SHALL sample SDA on 16 consecutive cycles into rdata[0]..rdata[15], LSB first, keeping SDA released; it then waits one cycle for the slave's trailing high bit and goes to DONE.
REQ-025 In DONE, SHALL pulse rdy=1 for exactly one cycle, drive SDA=1, and return to IDLE; a req seen in the DONE cycle is ignored.
REQ-026 SCL SHALL be 0 in every state except IDLE and DONE.
REQ-027 SHALL never drive SDA in the TA or RDATA states, and SHALL always drive SDA in every other state.
REQ-028 rdata SHALL be updated only by a completed, non-timed-out read, and SHALL hold its value otherwise.
REQ-029 A back-to-back req (high again on the first IDLE cycle after DONE) SHALL start a new frame with no extra delay.

Reset
REQ-030 When reset=1, SHALL enter IDLE immediately, regardless of the clock.
REQ-031 During reset, SHALL drive SDA=1, SCL=1, rdy=0, err=0, rdata=16'h0000, and clear all counters.
REQ-032 A reset mid-frame SHALL abort the frame with no rdy pulse; the slave recovers because the line returns high.

Structure
REQ-033 A shared package SHALL hold the state encoding enum, the frame lengths (ADDR_BITS=8, DATA_BITS=16), and the CMD_WRITE/CMD_READ constants.
REQ-034 SHALL consist of the FSM plus one natural sub-module, twm_shift16: a 16-bit LSB-first shift register with a load/shift-out/shift-in mode, used for both write data and read data.

Verification
REQ-035 Write addr=8'h3C, wdata=16'hA5F0 -> SDA sequence 0,1,(0,0,1,1,1,1,0,0),(0,0,0,0,1,1,1,1,1,0,1,0,0,1,0,1), then 1; rdy pulses 27 cycles after req.
REQ-036 Read addr=8'h01 with a slave model that returns 16'h1234 after a 2-cycle turnaround -> rdata=16'h1234, err=0, one rdy pulse.
REQ-037 Read with a silent slave (SDA pulled high) -> rdy and err pulse together 8 TA cycles after addr[7]; rdata retains its prior value.
REQ-038 Assert reset during WDATA bit 5 -> SDA=1, SCL=1, no rdy, FSM in IDLE; the next write completes correctly.
REQ-039 Issue a write then a read back-to-back to TPA connected through a pull-up -> the read returns the written value, and only one side drives SDA in any cycle.
